// File: rtl/gpio_pad_pkg.sv
// Shared register map and read-mux index type for the GPIO pad controller.
package gpio_pad_pkg;

  localparam int BUS_ADDR_W = 6;

  localparam logic [BUS_ADDR_W-1:0] GPIO_OUT       = 6'h00;
  localparam logic [BUS_ADDR_W-1:0] GPIO_OE        = 6'h04;
  localparam logic [BUS_ADDR_W-1:0] GPIO_CS        = 6'h08;
  localparam logic [BUS_ADDR_W-1:0] GPIO_SL        = 6'h0C;
  localparam logic [BUS_ADDR_W-1:0] GPIO_IE        = 6'h10;
  localparam logic [BUS_ADDR_W-1:0] GPIO_PU        = 6'h14;
  localparam logic [BUS_ADDR_W-1:0] GPIO_PD        = 6'h18;
  localparam logic [BUS_ADDR_W-1:0] GPIO_ALT_SEL   = 6'h1C;
  localparam logic [BUS_ADDR_W-1:0] GPIO_RISE_EN   = 6'h20;
  localparam logic [BUS_ADDR_W-1:0] GPIO_FALL_EN   = 6'h24;
  localparam logic [BUS_ADDR_W-1:0] GPIO_PEND      = 6'h28;
  localparam logic [BUS_ADDR_W-1:0] GPIO_BIDIR_IN  = 6'h2C;
  localparam logic [BUS_ADDR_W-1:0] GPIO_INPUT_IN  = 6'h30;
  localparam logic [BUS_ADDR_W-1:0] GPIO_INPUT_PU  = 6'h34;
  localparam logic [BUS_ADDR_W-1:0] GPIO_INPUT_PD  = 6'h38;

  typedef enum logic [3:0] {
    REG_OUT, REG_OE, REG_CS, REG_SL, REG_IE, REG_PU, REG_PD, REG_ALT_SEL,
    REG_RISE_EN, REG_FALL_EN, REG_PEND, REG_BIDIR_IN, REG_INPUT_IN,
    REG_INPUT_PU, REG_INPUT_PD, REG_NONE
  } reg_idx_e;

  // Byte-address decode; the two low address bits never select anything.
  function automatic reg_idx_e addr_to_idx(input logic [BUS_ADDR_W-1:2] word_addr);
    reg_idx_e idx;
    case ({word_addr, 2'b00})
      GPIO_OUT:      idx = REG_OUT;
      GPIO_OE:       idx = REG_OE;
      GPIO_CS:       idx = REG_CS;
      GPIO_SL:       idx = REG_SL;
      GPIO_IE:       idx = REG_IE;
      GPIO_PU:       idx = REG_PU;
      GPIO_PD:       idx = REG_PD;
      GPIO_ALT_SEL:  idx = REG_ALT_SEL;
      GPIO_RISE_EN:  idx = REG_RISE_EN;
      GPIO_FALL_EN:  idx = REG_FALL_EN;
      GPIO_PEND:     idx = REG_PEND;
      GPIO_BIDIR_IN: idx = REG_BIDIR_IN;
      GPIO_INPUT_IN: idx = REG_INPUT_IN;
      GPIO_INPUT_PU: idx = REG_INPUT_PU;
      GPIO_INPUT_PD: idx = REG_INPUT_PD;
      default:       idx = REG_NONE;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/gpio_pad_ctrl_sync2.sv
// Two-flop synchroniser bank for asynchronous pad inputs.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= d;
      s2_reg <= s1_reg;
    end
  end

  assign q = s2_reg;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// Register-mapped pad-ring controller: pad control registers, alternate-function
// mux, input synchronisation and edge interrupts.
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int NUM_BIDIR_PADS = 18,
  parameter int NUM_INPUT_PADS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BUS_ADDR_W-1:0]     bus_addr,
  input  logic [31:0]               bus_wdata,
  input  logic                      bus_we,
  input  logic                      bus_re,
  output logic [31:0]               bus_rdata,
  output logic                      irq,
  input  logic [NUM_BIDIR_PADS-1:0] periph_out,
  input  logic [NUM_BIDIR_PADS-1:0] periph_oe,
  output logic [NUM_BIDIR_PADS-1:0] periph_in,
  input  logic [NUM_BIDIR_PADS-1:0] bidir_in,
  output logic [NUM_BIDIR_PADS-1:0] bidir_out,
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
  input  logic [NUM_INPUT_PADS-1:0] input_in,
  output logic [NUM_INPUT_PADS-1:0] input_pu,
  output logic [NUM_INPUT_PADS-1:0] input_pd
);

  localparam int NB = NUM_BIDIR_PADS;
  localparam int NI = NUM_INPUT_PADS;

  logic [NB-1:0] out_reg, oe_reg, cs_reg, sl_reg, ie_reg, pu_reg, pd_reg, alt_reg;
  logic [NB-1:0] rise_en_reg, fall_en_reg, pend_reg, pend_next, s3_reg;
  logic [NI-1:0] in_pu_reg, in_pd_reg;
  logic [31:0]   rdata_reg, rdata_next;
  logic [NB-1:0] bidir_s2, edge_evt, pend_clr;
  logic [NI-1:0] input_s2;
  reg_idx_e      acc_idx;
  logic          unused_bus_bits;

  assign unused_bus_bits = ^{bus_addr[1:0], bus_wdata};
  assign acc_idx = addr_to_idx(bus_addr[BUS_ADDR_W-1:2]);

  sync2 #(.WIDTH(NB)) u_sync_bidir (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bidir_in),
    .q     (bidir_s2)
  );

  sync2 #(.WIDTH(NI)) u_sync_input (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (input_in),
    .q     (input_s2)
  );

  // An enabled edge arriving together with a write-1-clear keeps the bit set.
  always_comb begin
    edge_evt  = ((bidir_s2 & ~s3_reg) & rise_en_reg) | ((~bidir_s2 & s3_reg) & fall_en_reg);
    pend_clr  = (bus_we && acc_idx == REG_PEND) ? bus_wdata[NB-1:0] : '0;
    pend_next = (pend_reg & ~pend_clr) | edge_evt;
  end

  always_comb begin
    rdata_next = '0;
    case (acc_idx)
      REG_OUT:      rdata_next[NB-1:0] = out_reg;
      REG_OE:       rdata_next[NB-1:0] = oe_reg;
      REG_CS:       rdata_next[NB-1:0] = cs_reg;
      REG_SL:       rdata_next[NB-1:0] = sl_reg;
      REG_IE:       rdata_next[NB-1:0] = ie_reg;
      REG_PU:       rdata_next[NB-1:0] = pu_reg;
      REG_PD:       rdata_next[NB-1:0] = pd_reg;
      REG_ALT_SEL:  rdata_next[NB-1:0] = alt_reg;
      REG_RISE_EN:  rdata_next[NB-1:0] = rise_en_reg;
      REG_FALL_EN:  rdata_next[NB-1:0] = fall_en_reg;
      REG_PEND:     rdata_next[NB-1:0] = pend_reg;
      REG_BIDIR_IN: rdata_next[NB-1:0] = bidir_s2;
      REG_INPUT_IN: rdata_next[NI-1:0] = input_s2;
      REG_INPUT_PU: rdata_next[NI-1:0] = in_pu_reg;
      REG_INPUT_PD: rdata_next[NI-1:0] = in_pd_reg;
      default:      rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_reg     <= '0;
      oe_reg      <= '0;
      cs_reg      <= '0;
      sl_reg      <= '0;
      ie_reg      <= '1;
      pu_reg      <= '0;
      pd_reg      <= '0;
      alt_reg     <= '0;
      rise_en_reg <= '0;
      fall_en_reg <= '0;
      pend_reg    <= '0;
      s3_reg      <= '0;
      in_pu_reg   <= '0;
      in_pd_reg   <= '0;
      rdata_reg   <= '0;
    end else begin
      s3_reg   <= bidir_s2;
      pend_reg <= pend_next;
      if (bus_re) rdata_reg <= rdata_next;
      if (bus_we) begin
        case (acc_idx)
          REG_OUT:      out_reg     <= bus_wdata[NB-1:0];
          REG_OE:       oe_reg      <= bus_wdata[NB-1:0];
          REG_CS:       cs_reg      <= bus_wdata[NB-1:0];
          REG_SL:       sl_reg      <= bus_wdata[NB-1:0];
          REG_IE:       ie_reg      <= bus_wdata[NB-1:0];
          REG_PU:       pu_reg      <= bus_wdata[NB-1:0];
          REG_PD:       pd_reg      <= bus_wdata[NB-1:0];
          REG_ALT_SEL:  alt_reg     <= bus_wdata[NB-1:0];
          REG_RISE_EN:  rise_en_reg <= bus_wdata[NB-1:0];
          REG_FALL_EN:  fall_en_reg <= bus_wdata[NB-1:0];
          REG_INPUT_PU: in_pu_reg   <= bus_wdata[NI-1:0];
          REG_INPUT_PD: in_pd_reg   <= bus_wdata[NI-1:0];
          default: ;
        endcase
      end
    end
  end

  // Per-pad mux; pull-up takes precedence when both pulls are requested.
  for (genvar gi = 0; gi < NB; gi++) begin : g_bidir
    assign bidir_out[gi] = alt_reg[gi] ? periph_out[gi] : out_reg[gi];
    assign bidir_oe[gi]  = alt_reg[gi] ? periph_oe[gi]  : oe_reg[gi];
    assign bidir_pd[gi]  = pd_reg[gi] & ~pu_reg[gi];
  end

  for (genvar gi = 0; gi < NI; gi++) begin : g_input
    assign input_pd[gi] = in_pd_reg[gi] & ~in_pu_reg[gi];
  end

  assign bidir_cs  = cs_reg;
  assign bidir_sl  = sl_reg;
  assign bidir_ie  = ie_reg;
  assign bidir_pu  = pu_reg;
  assign input_pu  = in_pu_reg;
  assign periph_in = bidir_s2;
  assign bus_rdata = rdata_reg;
  assign irq       = |pend_reg;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed self-checking bench for gpio_pad_ctrl; all driving and sampling on negedge.
module tb_gpio_pad_ctrl;

  localparam int NB = 18;
  localparam int NI = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    bus_addr;
  logic [31:0]   bus_wdata;
  logic          bus_we, bus_re;
  logic [31:0]   bus_rdata;
  logic          irq;
  logic [NB-1:0] periph_out, periph_oe, periph_in, bidir_in;
  logic [NB-1:0] bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
  logic [NI-1:0] input_in, input_pu, input_pd;

  int total = 0;
  int bad = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  gpio_pad_ctrl #(.NUM_BIDIR_PADS(NB), .NUM_INPUT_PADS(NI)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_rdata  (bus_rdata),
    .irq        (irq),
    .periph_out (periph_out),
    .periph_oe  (periph_oe),
    .periph_in  (periph_in),
    .bidir_in   (bidir_in),
    .bidir_out  (bidir_out),
    .bidir_oe   (bidir_oe),
    .bidir_cs   (bidir_cs),
    .bidir_sl   (bidir_sl),
    .bidir_ie   (bidir_ie),
    .bidir_pu   (bidir_pu),
    .bidir_pd   (bidir_pd),
    .input_in   (input_in),
    .input_pu   (input_pu),
    .input_pd   (input_pd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Bus tasks are entered and left on a negedge.
  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    @(negedge clk);
    bus_we = 1'b0;
    $display("wr addr=0x%02h data=0x%08h", a, d);
  endtask

  task automatic rdreg(input logic [5:0] a, output logic [31:0] d);
    bus_addr = a; bus_re = 1'b1;
    @(negedge clk);
    bus_re = 1'b0;
    d = bus_rdata;
    $display("rd addr=0x%02h data=0x%08h", a, d);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; bus_addr = '0; bus_wdata = '0; bus_we = 1'b0; bus_re = 1'b0;
    periph_out = '0; periph_oe = '0; bidir_in = '0; input_in = '0;
    cycles(3);
    rst_n = 1'b1;

    // 1: reset state
    chk("rst_rdata", bus_rdata, 32'h0);
    chk("rst_oe", 32'(bidir_oe), 32'h0);
    chk("rst_ie", 32'(bidir_ie), 32'h3FFFF);
    chk("rst_irq", 32'(irq), 32'h0);
    for (int a = 0; a < 64; a += 4) begin
      rdreg(6'(a), rd);
      chk($sformatf("rst_reg_%02h", a), rd, (a == 'h10) ? 32'h3FFFF : 32'h0);
    end

    // 2: plain outputs, width masking, RO and unmapped writes
    wr(6'h00, 32'h5);
    wr(6'h04, 32'h7);
    chk("out_2_0", 32'(bidir_out[2:0]), 32'h5);
    chk("oe_2_0", 32'(bidir_oe[2:0]), 32'h7);
    wr(6'h00, 32'hFFFF_FFFF);
    rdreg(6'h00, rd);
    chk("out_mask", rd, 32'h3FFFF);
    wr(6'h2C, 32'hFFFF_FFFF);
    rdreg(6'h2C, rd);
    chk("bidir_in_ro", rd, 32'h0);
    wr(6'h3C, 32'hFFFF_FFFF);
    rdreg(6'h3C, rd);
    chk("unmapped", rd, 32'h0);
    bus_addr = 6'h08; bus_wdata = 32'h3; bus_we = 1'b1; bus_re = 1'b1;
    @(negedge clk);
    bus_we = 1'b0; bus_re = 1'b0;
    chk("rw_same_cycle", bus_rdata, 32'h0);
    chk("cs_after_rw", 32'(bidir_cs), 32'h3);

    // 3: alternate function
    wr(6'h00, 32'h0);
    periph_out[4] = 1'b1; periph_oe[4] = 1'b1;
    wr(6'h1C, 32'h10);
    chk("alt_out4", 32'(bidir_out[4]), 32'h1);
    chk("alt_oe4", 32'(bidir_oe[4]), 32'h1);
    wr(6'h1C, 32'h0);
    chk("gpio_out4", 32'(bidir_out[4]), 32'h0);
    chk("gpio_oe4", 32'(bidir_oe[4]), 32'h0);

    // 4: rising edge interrupt, clear, masked falling edge
    wr(6'h20, 32'h8);
    bidir_in[3] = 1'b1;
    cycles(1);
    chk("sync_lat1", 32'(periph_in[3]), 32'h0);
    cycles(1);
    chk("sync_lat2", 32'(periph_in[3]), 32'h1);
    chk("irq_lat2", 32'(irq), 32'h0);
    cycles(1);
    chk("irq_lat3", 32'(irq), 32'h1);
    rdreg(6'h2C, rd);
    chk("bidir_in_rd", rd, 32'h8);
    rdreg(6'h28, rd);
    chk("pend_rise", rd, 32'h8);
    wr(6'h28, 32'h8);
    chk("irq_clr", 32'(irq), 32'h0);
    bidir_in[3] = 1'b0;
    cycles(5);
    chk("fall_masked", 32'(irq), 32'h0);

    // 5: set beats simultaneous clear; disabling enable keeps pending
    bidir_in[3] = 1'b1;
    cycles(2);
    wr(6'h28, 32'h8);
    chk("set_wins_irq", 32'(irq), 32'h1);
    rdreg(6'h28, rd);
    chk("set_wins_pend", rd, 32'h8);
    wr(6'h20, 32'h0);
    chk("disable_keeps", 32'(irq), 32'h1);

    // 6: pull conflicts, then reset mid-operation
    wr(6'h14, 32'h1);
    wr(6'h18, 32'h1);
    wr(6'h34, 32'h80);
    wr(6'h38, 32'h80);
    chk("pu0", 32'(bidir_pu[0]), 32'h1);
    chk("pd0_forced", 32'(bidir_pd[0]), 32'h0);
    chk("in_pu7", 32'(input_pu[7]), 32'h1);
    chk("in_pd7_forced", 32'(input_pd[7]), 32'h0);
    rdreg(6'h18, rd);
    chk("pd_readback", rd, 32'h1);
    rdreg(6'h38, rd);
    chk("in_pd_readback", rd, 32'h80);
    wr(6'h18, 32'h2);
    chk("pd1_no_conflict", 32'(bidir_pd), 32'h2);
    wr(6'h00, 32'h3);
    wr(6'h04, 32'h3);
    rst_n = 1'b0; bus_addr = 6'h10; bus_re = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; bus_re = 1'b0;
    chk("rst2_rdata", bus_rdata, 32'h0);
    chk("rst2_out", 32'(bidir_out), 32'h0);
    chk("rst2_oe", 32'(bidir_oe), 32'h0);
    chk("rst2_ie", 32'(bidir_ie), 32'h3FFFF);
    chk("rst2_pu", 32'(bidir_pu), 32'h0);
    chk("rst2_pd", 32'(bidir_pd), 32'h0);
    chk("rst2_cs", 32'(bidir_cs), 32'h0);
    chk("rst2_in_pu", 32'(input_pu), 32'h0);
    chk("rst2_irq", 32'(irq), 32'h0);
    cycles(4);
    chk("idle_high_masked", 32'(irq), 32'h0);
    rdreg(6'h28, rd);
    chk("rst2_pend", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_pad_ctrl.md
Name: gpio_pad_ctrl

Overview:
- Register-mapped controller between the core bus and the chip's pad ring.
- Drives every control pin of the bidirectional pads (out, oe, cs, sl, ie, pu, pd) and the pull controls of the input-only pads.
- Synchronises pad inputs and raises edge interrupts.
- Has a per-pad alternate-function mux so peripherals (UART, I2C master) can take over individual bidir pads.

Parameters:
- NUM_BIDIR_PADS, 18, number of bidirectional pads (1..32).
- NUM_INPUT_PADS, 8, number of input-only pads (1..32).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous active-low reset.
- bus_addr  in  6  byte address; bits [1:0] ignored.
- bus_wdata  in  32  write data.
- bus_we  in  1  write strobe, single cycle.
- bus_re  in  1  read strobe, single cycle.
- bus_rdata  out  32  read data, registered.
- irq  out  1  OR of all pending interrupt bits.
- periph_out  in  NUM_BIDIR_PADS  alternate-function output data.
- periph_oe  in  NUM_BIDIR_PADS  alternate-function output enable.
- periph_in  out  NUM_BIDIR_PADS  synchronised bidir inputs to peripherals.
- bidir_in  in  NUM_BIDIR_PADS  raw pad Y.
- bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd  out  NUM_BIDIR_PADS each  pad controls.
- input_in  in  NUM_INPUT_PADS  raw input pad Y.
- input_pu, input_pd  out  NUM_INPUT_PADS each  input pad pulls.

Behaviour:
- One clock domain (clk). Reset is synchronous, active-low (rst_n), and applies on a clk edge while rst_n=0.
- Register map (byte offsets):
  - 0x00 OUT, 0x04 OE, 0x08 CS, 0x0C SL, 0x10 IE, 0x14 PU, 0x18 PD, 0x1C ALT_SEL.
  - 0x20 RISE_EN, 0x24 FALL_EN, 0x28 PEND (write-1-to-clear).
  - 0x2C BIDIR_IN (RO), 0x30 INPUT_IN (RO), 0x34 INPUT_PU, 0x38 INPUT_PD.
- Register width and unmapped accesses:
  - Bits at or above the pad count read 0 and ignore writes.
  - Unmapped addresses read 0; writes to them have no effect.
  - Writes to read-only registers are ignored.
- Reset values:
  - All registers 0, except IE = all ones.
  - bus_rdata = 0, irq = 0, all synchroniser flops = 0.
  - Consequently every pad is an input with its receiver enabled and no pulls.
- Writes take effect at the clk edge where bus_we=1; the new value appears on pad outputs in the next cycle.
- Reads: bus_rdata is updated on the edge where bus_re=1 and holds until the next read.
  - If bus_we and bus_re are both high, the read returns the pre-write value.
- Pad mux, combinational from registers:
  - ALT_SEL[i]=1: bidir_out[i]=periph_out[i] and bidir_oe[i]=periph_oe[i].
  - ALT_SEL[i]=0: bidir_out[i]=OUT[i] and bidir_oe[i]=OE[i].
  - cs, sl, ie, pu, pd always come from their registers.
- Pull conflict: if PU[i] and PD[i] are both 1, bidir_pd[i] is forced 0 (pull-up wins). The same rule applies to INPUT_PU/INPUT_PD. Register readback shows the written values.
- Synchronisation:
  - Each bidir_in and input_in bit passes through a 2-flop synchroniser (s1, s2).
  - BIDIR_IN and periph_in show s2, i.e. 2 cycles latency from the pad.
- Edge detection (bidir pads only):
  - A third flop s3 captures s2.
  - rise[i] = s2 & ~s3; fall[i] = ~s2 & s3.
  - PEND[i] is set on the next edge when (rise & RISE_EN) | (fall & FALL_EN).
- irq is combinational OR of PEND. A pad change appears on irq 3 cycles after it is sampled.
- Simultaneous set and write-1-clear of the same PEND bit: set wins, and the bit stays 1.
- Disabling RISE_EN/FALL_EN does not clear existing PEND bits.
- Reset mid-operation:
  - All state returns to reset values on the next edge.
  - Pending bits are lost.
  - A read in progress returns 0.
- The edge detector ignores the transition caused by leaving reset: s3 and s2 are both 0 during reset, so there is no spurious edge if a pad idles low. A pad idling high produces one rise event, masked by RISE_EN=0 at reset.

Decomposition:
- Package gpio_pad_pkg:
  - Register offset localparams (GPIO_OUT ... GPIO_INPUT_PD).
  - Bus address width constant.
  - Register-index enum used by the read mux.
- Sub-module sync2: parameterised-width 2-flop synchroniser with synchronous active-low reset, instantiated once for bidir inputs and once for input-only pads.

Test Plan:
1. Reset then read all registers → IE reads 0x3FFFF, all others 0; bidir_oe=0, bidir_ie all 1, irq=0.
2. Write OUT=0x00005, OE=0x00007 → next cycle bidir_out[2:0]=3'b101 and bidir_oe[2:0]=3'b111; write 0xFFFFFFFF to OUT → readback 0x3FFFF.
3. Set ALT_SEL[4]=1, drive periph_out[4]=1 and periph_oe[4]=1 with OUT[4]=0 → bidir_out[4]=1 and bidir_oe[4]=1; clear ALT_SEL → bidir_out[4]=0.
4. RISE_EN[3]=1, toggle bidir_in[3] 0→1 → BIDIR_IN[3]=1 after 2 cycles, PEND=0x8 and irq=1 after 3 cycles; write PEND=0x8 → irq=0; falling edge with FALL_EN=0 → no irq.
5. Clear PEND[3] in the same cycle a new enabled rise arrives → PEND[3] stays 1.
6. Write PU=PD=0x1 and INPUT_PU=INPUT_PD=0x80 → bidir_pu[0]=1, bidir_pd[0]=0, input_pd[7]=0; registers read back written values; then assert rst_n=0 for one cycle → all outputs return to reset values.
